leaf_switch: RTL and testbench

//  First-level NoC switch directly downstream of the GPU network interfaces (NIs). Terminates NUM_LEAF
//  NI ports of one group plus one uplink to the group router. Routes 16-bit flits on header
//  {group[15:12], leaf[11:10]}: own group -> local leaf egress; other group -> uplink; uplink -> leaf.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_flit_fifo.sv | 44 ++++
 rtl/leaf_switch.sv | 156 +++++++++++++++
 tb/tb_leaf_switch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit header layout and field helpers used by the NI,
// the leaf switch and the group router.
package noc_pkg;
    localparam int DATA_W   = 16;
    localparam int HEADER_W = 6;
    localparam int GRP_MSB  = 15;
    localparam int GRP_LSB  = 12;
    localparam int LEAF_MSB = 11;
    localparam int LEAF_LSB = 10;
    localparam int GRP_W    = GRP_MSB - GRP_LSB + 1;
    localparam int LEAF_W   = LEAF_MSB - LEAF_LSB + 1;

    typedef logic [DATA_W-1:0] flit_t;
    typedef logic [GRP_W-1:0]  grp_t;
    typedef logic [LEAF_W-1:0] leaf_t;

    function automatic grp_t flit_group(input flit_t f);
        return f[GRP_MSB:GRP_LSB];
    endfunction

    function automatic leaf_t flit_leaf(input flit_t f);
        return f[LEAF_MSB:LEAF_LSB];
    endfunction

    // An all-zero header is never a legal destination.
    function automatic logic flit_null(input flit_t f);
        return f[DATA_W-1 -: HEADER_W] == '0;
    endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// Ingress flit FIFO. Push and pop in the same cycle are both honored, so a full
// FIFO still accepts a flit on the cycle its head leaves.
module noc_flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/leaf_switch.sv
// First-level NoC switch: NUM_LEAF NI ports plus one uplink, per-input FIFOs,
// header routing and a round-robin arbiter per output.
module leaf_switch
    import noc_pkg::*;
#(
    parameter int   DATA_W     = 16,
    parameter int   NUM_LEAF   = 4,
    parameter grp_t MY_GROUP   = 4'd1,
    parameter int   FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LEAF*DATA_W-1:0]   leaf_in_data,
    input  logic [NUM_LEAF-1:0]          leaf_in_valid,
    output logic [NUM_LEAF-1:0]          leaf_in_ready,
    output logic [NUM_LEAF*DATA_W-1:0]   leaf_out_data,
    output logic [NUM_LEAF-1:0]          leaf_out_valid,
    input  logic [DATA_W-1:0]            up_in_data,
    input  logic                         up_in_valid,
    output logic                         up_in_ready,
    output logic [DATA_W-1:0]            up_out_data,
    output logic                         up_out_valid,
    input  logic                         up_out_ready,
    output logic [7:0]                   drop_count
);
    localparam int NIN  = NUM_LEAF + 1;
    localparam int NOUT = NUM_LEAF + 1;
    localparam int UP   = NUM_LEAF;
    localparam int PW   = $clog2(NIN);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int DSW  = $clog2(2*NIN + 1);

    logic [NIN-1:0]             in_push, in_pop, in_full, in_empty;
    logic [NIN-1:0]             head_drop, push_drop;
    logic [NIN-1:0][DATA_W-1:0] in_data, head;
    logic [NIN-1:0][CW-1:0]     in_count;
    logic [NOUT-1:0][NIN-1:0]   req, gnt;
    logic [NOUT-1:0][PW-1:0]    gnt_sel;
    logic [NOUT-1:0]            gnt_any;
    logic                       up_free;
    logic [DSW-1:0]             drop_sum;
    logic [8:0]                 drop_total;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NIN) s = s - NIN;
        return PW'(s);
    endfunction

    // Leaf credit leaves one slot for the flit already in flight from the NI register.
    for (genvar i = 0; i < NUM_LEAF; i++) begin : g_leaf_in
        assign in_push[i]       = leaf_in_valid[i];
        assign in_data[i]       = leaf_in_data[i*DATA_W +: DATA_W];
        assign leaf_in_ready[i] = !reset && (in_count[i] <= CW'(FIFO_DEPTH-2));
    end
    assign up_in_ready = !reset && (in_count[UP] <= CW'(FIFO_DEPTH-1));
    assign in_push[UP] = up_in_valid && up_in_ready;
    assign in_data[UP] = up_in_data;

    for (genvar j = 0; j < NIN; j++) begin : g_fifo
        noc_flit_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_push[j]),
            .push_data (in_data[j]),
            .pop       (in_pop[j]),
            .pop_data  (head[j]),
            .full      (in_full[j]),
            .empty     (in_empty[j]),
            .count     (in_count[j])
        );
    end

    assign up_free = !up_out_valid || up_out_ready;

    always_comb begin
        req       = '0;
        head_drop = '0;
        for (int j = 0; j < NIN; j++) begin
            if (!in_empty[j]) begin
                if (j < UP && flit_null(head[j]))
                    head_drop[j] = 1'b1;
                else if (flit_group(head[j]) == MY_GROUP)
                    req[flit_leaf(head[j])][j] = 1'b1;
                else if (j < UP)
                    req[UP][j] = up_free;
                else
                    head_drop[j] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < NOUT; o++) begin : g_arb
        logic [PW-1:0] ptr, sel;
        logic          any;

        // Scan from farthest to nearest so the request closest to ptr wins.
        always_comb begin
            sel = '0;
            any = 1'b0;
            for (int k = NIN-1; k >= 0; k--) begin
                if (req[o][rr_idx(ptr, k)]) begin
                    sel = rr_idx(ptr, k);
                    any = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset)    ptr <= '0;
            else if (any) ptr <= rr_idx(sel, 1);
        end

        assign gnt_any[o] = any;
        assign gnt_sel[o] = sel;
        assign gnt[o]     = any ? (NIN'(1) << sel) : '0;
    end

    always_comb begin
        in_pop = head_drop;
        for (int o = 0; o < NOUT; o++)
            in_pop = in_pop | gnt[o];
    end

    assign push_drop = in_push & in_full & ~in_pop;

    always_comb begin
        drop_sum = '0;
        for (int j = 0; j < NIN; j++)
            drop_sum = drop_sum + DSW'(head_drop[j]) + DSW'(push_drop[j]);
        drop_total = {1'b0, drop_count} + 9'(drop_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leaf_out_valid <= '0;
            leaf_out_data  <= '0;
            up_out_valid   <= 1'b0;
            up_out_data    <= '0;
            drop_count     <= '0;
        end else begin
            for (int o = 0; o < NUM_LEAF; o++) begin
                leaf_out_valid[o] <= gnt_any[o];
                if (gnt_any[o]) leaf_out_data[o*DATA_W +: DATA_W] <= head[gnt_sel[o]];
            end
            if (gnt_any[UP]) begin
                up_out_valid <= 1'b1;
                up_out_data  <= head[gnt_sel[UP]];
            end else if (up_out_ready) begin
                up_out_valid <= 1'b0;
            end
            drop_count <= drop_total[8] ? 8'hFF : drop_total[7:0];
        end
    end
endmodule

// File: tb/tb_leaf_switch.sv
// Directed bench for leaf_switch: routing vector table plus hand-written
// sequences for backpressure, arbitration, drops, credit and reset.
module tb_leaf_switch;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] leaf_in_data, leaf_out_data;
    logic [3:0]  leaf_in_valid, leaf_in_ready, leaf_out_valid;
    logic [15:0] up_in_data, up_out_data;
    logic        up_in_valid, up_in_ready, up_out_valid, up_out_ready;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;
    int exp_drops = 0;

    typedef struct {
        int          src;
        logic [15:0] flit;
        logic [3:0]  exp_leaf;
        logic        exp_up;
        int          drop_inc;
    } vec_t;
    vec_t vecs[10];
    int order[4] = '{0, 1, 3, 4};

    leaf_switch #(.DATA_W(16), .NUM_LEAF(4), .MY_GROUP(4'd1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid), .leaf_in_ready(leaf_in_ready),
        .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
        .up_in_data(up_in_data), .up_in_valid(up_in_valid), .up_in_ready(up_in_ready),
        .up_out_data(up_out_data), .up_out_valid(up_out_valid), .up_out_ready(up_out_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input int src, input logic [15:0] f);
        if (src < 4) begin
            leaf_in_valid[src]        = 1'b1;
            leaf_in_data[src*16 +: 16] = f;
        end else begin
            up_in_valid = 1'b1;
            up_in_data  = f;
        end
    endtask

    task automatic idle_inputs;
        leaf_in_valid = '0;
        up_in_valid   = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_lv"}, 32'(leaf_out_valid), 0);
        check({tag, "_ld"}, leaf_out_data[31:0], 0);
        check({tag, "_ld_hi"}, leaf_out_data[63:32], 0);
        check({tag, "_uv"}, 32'(up_out_valid), 0);
        check({tag, "_ud"}, 32'(up_out_data), 0);
        check({tag, "_drop"}, 32'(drop_count), 0);
    endtask

    initial begin
        int sent;
        logic rdy_q;
        logic [15:0] e;

        reset = 1'b1;
        leaf_in_data = '0; leaf_in_valid = '0;
        up_in_data = '0; up_in_valid = 1'b0; up_out_ready = 1'b1;

        vecs[0] = '{0, 16'h1A55, 4'b0100, 1'b0, 0};  // own group, leaf 2
        vecs[1] = '{3, 16'h1C00, 4'b1000, 1'b0, 0};  // leaf 3
        vecs[2] = '{2, 16'h1800, 4'b0100, 1'b0, 0};  // hairpin to self
        vecs[3] = '{1, 16'h2C01, 4'b0000, 1'b1, 0};  // other group -> uplink
        vecs[4] = '{4, 16'h1412, 4'b0010, 1'b0, 0};  // uplink -> leaf 1
        vecs[5] = '{4, 16'h3000, 4'b0000, 1'b0, 1};  // uplink misroute
        vecs[6] = '{0, 16'h0000, 4'b0000, 1'b0, 1};  // null header
        vecs[7] = '{1, 16'h03FF, 4'b0000, 1'b0, 1};  // null header, payload set
        vecs[8] = '{2, 16'hF000, 4'b0000, 1'b1, 0};  // group 15 -> uplink
        vecs[9] = '{4, 16'h10AB, 4'b0001, 1'b0, 0};  // uplink -> leaf 0

        repeat (2) tick;
        check("rst_lrdy", 32'(leaf_in_ready), 0);
        check("rst_urdy", 32'(up_in_ready), 0);
        check_zero_outputs("rst");
        reset = 1'b0;
        tick;
        check("post_rst_lrdy", 32'(leaf_in_ready), 32'hF);
        check("post_rst_urdy", 32'(up_in_ready), 1);

        // Four sources contend for leaf 2: strict rotation 0,1,3,up.
        for (int c = 0; c < 15; c++) begin
            idle_inputs();
            if (c < 3) begin
                check("t3_urdy", 32'(up_in_ready), 1);
                for (int s = 0; s < 4; s++)
                    drive(order[s], 16'h1800 | 16'(order[s] * 16) | 16'(c));
            end
            if (c >= 2 && c < 14) begin
                e = 16'h1800 | 16'(order[(c-2) % 4] * 16) | 16'((c-2) / 4);
                check("t3_lv", 32'(leaf_out_valid), 32'h4);
                check("t3_ld", 32'(leaf_out_data[32 +: 16]), 32'(e));
            end
            if (c == 14) check("t3_quiet", 32'(leaf_out_valid), 0);
            tick;
        end
        check("t3_drop", 32'(drop_count), 0);

        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].src, vecs[v].flit);
            tick;
            idle_inputs();
            tick;
            check("tbl_lv", 32'(leaf_out_valid), 32'(vecs[v].exp_leaf));
            for (int l = 0; l < 4; l++)
                if (vecs[v].exp_leaf[l])
                    check("tbl_ld", 32'(leaf_out_data[l*16 +: 16]), 32'(vecs[v].flit));
            check("tbl_uv", 32'(up_out_valid), 32'(vecs[v].exp_up));
            if (vecs[v].exp_up) check("tbl_ud", 32'(up_out_data), 32'(vecs[v].flit));
            exp_drops += vecs[v].drop_inc;
            check("tbl_drop", 32'(drop_count), 32'(exp_drops));
            tick;
            check("tbl_quiet_lv", 32'(leaf_out_valid), 0);
            check("tbl_quiet_uv", 32'(up_out_valid), 0);
        end

        // Uplink egress held under backpressure, one transfer on release.
        up_out_ready = 1'b0;
        drive(1, 16'h2C01);
        tick;
        idle_inputs();
        tick;
        for (int k = 0; k < 5; k++) begin
            check("t2_uv", 32'(up_out_valid), 1);
            check("t2_ud", 32'(up_out_data), 32'h2C01);
            tick;
        end
        up_out_ready = 1'b1;
        tick;
        check("t2_uv_rel", 32'(up_out_valid), 0);
        tick;
        check("t2_uv_rel2", 32'(up_out_valid), 0);

        // Leaf 2 streams to a blocked uplink, NI honoring credit with one cycle of lag.
        up_out_ready = 1'b0;
        sent = 0;
        rdy_q = 1'b0;
        for (int c = 0; c < 20; c++) begin
            leaf_in_valid[2] = rdy_q;
            if (rdy_q) begin
                leaf_in_data[32 +: 16] = 16'h5000 | 16'(sent);
                sent++;
            end
            rdy_q = leaf_in_ready[2];
            tick;
        end
        idle_inputs();
        check("t5_sent", 32'(sent), 5);
        check("t5_rdy", 32'(leaf_in_ready[2]), 0);
        check("t5_drop", 32'(drop_count), 32'(exp_drops));
        up_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t5_uv", 32'(up_out_valid), 1);
            check("t5_ud", 32'(up_out_data), 32'h5000 + 32'(k));
            tick;
        end
        check("t5_uv_end", 32'(up_out_valid), 0);
        check("t5_rdy_end", 32'(leaf_in_ready[2]), 1);

        // Five drops in one cycle, then saturation.
        for (int s = 0; s < 4; s++) drive(s, 16'h0000);
        drive(4, 16'h3000);
        tick;
        idle_inputs();
        tick;
        exp_drops += 5;
        check("t4_multi_drop", 32'(drop_count), 32'(exp_drops));
        check("t4_quiet_lv", 32'(leaf_out_valid), 0);
        check("t4_quiet_uv", 32'(up_out_valid), 0);
        for (int k = 0; k < 260; k++) begin
            drive(4, 16'h3000);
            tick;
        end
        idle_inputs();
        repeat (2) tick;
        check("t4_sat", 32'(drop_count), 32'hFF);

        // Reset with flits sitting in every FIFO.
        up_out_ready = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 16'h5100 | 16'(s));
        drive(4, 16'h1800);
        tick;
        idle_inputs();
        reset = 1'b1;
        tick;
        check("t6_lrdy", 32'(leaf_in_ready), 0);
        check("t6_urdy", 32'(up_in_ready), 0);
        check_zero_outputs("t6_in");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_zero_outputs("t6_post");
            check("t6_post_lrdy", 32'(leaf_in_ready), 32'hF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
